// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// Optional stall/wait cycle counter is enabled by defining IF_STALL_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [15:0] id_imm16,
`ifdef IF_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        id_valid
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc4;
  logic        r_id_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc4;
  logic        w_fire;
  logic [31:0] w_pc4;
  logic [31:0] w_redirect_pc;

  assign w_pc4         = r_pc + 32'd4;
  assign w_redirect_pc = redirect_pc & ~32'h3;
  assign imem_addr     = r_pc;
  assign id_instr      = r_id_instr;
  assign id_pc4        = r_id_pc4;
  assign id_imm16      = r_id_instr[15:0];
  assign id_valid      = r_id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // The skid buffer is full exactly while the FSM sits in S_HOLD.
  always_comb begin
    w_state_next = r_state;
    imem_req     = (r_state == S_FETCH);
    w_fire       = imem_req & imem_ready;
    if (redirect || flush) begin
      w_state_next = S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_FETCH;
        S_FETCH: if (w_fire && stall) w_state_next = S_HOLD;
        S_HOLD:  if (!stall) w_state_next = S_FETCH;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_id_instr   <= 32'h0;
      r_id_pc4     <= 32'h0;
      r_id_valid   <= 1'b0;
      r_skid_instr <= 32'h0;
      r_skid_pc4   <= 32'h0;
    end else if (redirect) begin
      r_pc       <= w_redirect_pc;
      r_id_valid <= 1'b0;
    end else if (flush) begin
      r_id_valid <= 1'b0;
      r_id_instr <= 32'h0;
      if (w_fire) r_pc <= w_pc4;
    end else if (stall) begin
      if (w_fire) begin
        r_skid_instr <= imem_rdata;
        r_skid_pc4   <= w_pc4;
        r_pc         <= w_pc4;
      end
    end else if (r_state == S_HOLD) begin
      r_id_instr <= r_skid_instr;
      r_id_pc4   <= r_skid_pc4;
      r_id_valid <= 1'b1;
    end else if (w_fire) begin
      r_id_instr <= imem_rdata;
      r_id_pc4   <= w_pc4;
      r_id_valid <= 1'b1;
      r_pc       <= w_pc4;
    end else begin
      r_id_valid <= 1'b0;
    end
  end

`ifdef IF_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Counts cycles lost to hazards or to imem wait states; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall_cnt <= 32'h0;
    else if (stall || ((r_state == S_FETCH) && !imem_ready)) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard testbench for if_stage: directed fetch/stall/redirect/flush/wait vectors,
// plus a second instance exercising PC wrap-around from RESET_PC=32'hFFFF_FFFC.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imemAddr, imemRdata, redirectPc;
  logic        imemReq, imemReady, stall, flush, redirect;
  logic [31:0] idInstr, idPc4;
  logic [15:0] idImm16;
  logic        idValid;

  logic [31:0] addr5, rdata5, instr5, pc4_5;
  logic        req5, valid5;
  logic [15:0] imm5;
  logic        one = 1'b1;
  logic        zero = 1'b0;
  logic [31:0] zero32 = 32'h0;

`ifdef IF_STALL_CNT_EN
  logic [31:0] stallCnt, stallCnt5;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] expQ[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: memWord = 32'h2008_7FFF;
      32'h0000_0004: memWord = 32'h8C09_FFFC;
      32'h0000_0008: memWord = 32'h0128_5020;
      32'h0040_0000: memWord = 32'h0800_0010;
      default:       memWord = {16'hDEAD, a[15:0]};
    endcase
  endfunction

  assign imemRdata = memWord(imemAddr);
  assign rdata5    = memWord(addr5);

  if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imemAddr), .imem_req(imemReq), .imem_rdata(imemRdata), .imem_ready(imemReady),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirectPc),
    .id_instr(idInstr), .id_pc4(idPc4), .id_imm16(idImm16),
`ifdef IF_STALL_CNT_EN
    .stall_cnt(stallCnt),
`endif
    .id_valid(idValid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(addr5), .imem_req(req5), .imem_rdata(rdata5), .imem_ready(one),
    .stall(zero), .flush(zero), .redirect(zero), .redirect_pc(zero32),
    .id_instr(instr5), .id_pc4(pc4_5), .id_imm16(imm5),
`ifdef IF_STALL_CNT_EN
    .stall_cnt(stallCnt5),
`endif
    .id_valid(valid5)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let the DUT consume them on the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic s, input logic f, input logic r, input logic [31:0] rpc, input logic rdy);
    stall      = s;
    flush      = f;
    redirect   = r;
    redirectPc = rpc;
    imemReady  = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every newly presented valid IF/ID word is popped and compared against the scoreboard.
  initial begin
    logic        prevValid;
    logic [31:0] prevInstr, prevPc4;
    logic [63:0] item;
    prevValid = 1'b0;
    prevInstr = 32'h0;
    prevPc4   = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && idValid && (!prevValid || idInstr !== prevInstr || idPc4 !== prevPc4)) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %h/%h expected none", idInstr, idPc4);
        end else begin
          item = expQ.pop_front();
          checkOutput("mon_instr", idInstr, item[63:32]);
          checkOutput("mon_pc4", idPc4, item[31:0]);
        end
      end
      prevValid = idValid;
      prevInstr = idInstr;
      prevPc4   = idPc4;
    end
  end

  initial begin
    stall = 0; flush = 0; redirect = 0; redirectPc = 0; imemReady = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_id_valid", {31'h0, idValid}, 32'h0);
    checkOutput("rst_imem_req", {31'h0, imemReq}, 32'h0);
    checkOutput("rst_imem_addr", imemAddr, 32'h0);
    checkOutput("rst_id_instr", idInstr, 32'h0);
    rst_n = 1'b1;
    checkOutput("idle_imem_req", {31'h0, imemReq}, 32'h0);

    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("fetch_imem_req", {31'h0, imemReq}, 32'h1);
    checkOutput("fetch_imem_addr", imemAddr, 32'h0);
    checkOutput("fetch_id_valid", {31'h0, idValid}, 32'h0);
    checkOutput("wrap_addr_start", addr5, 32'hFFFF_FFFC);

    expQ.push_back({32'h2008_7FFF, 32'h0000_0004});
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("first_imm16", {16'h0, idImm16}, 32'h0000_7FFF);
    checkOutput("first_imem_addr", imemAddr, 32'h4);
    checkOutput("first_id_valid", {31'h0, idValid}, 32'h1);
    checkOutput("wrap_pc4", pc4_5, 32'h0);
    checkOutput("wrap_addr", addr5, 32'h0);
    checkOutput("wrap_instr", instr5, 32'hDEAD_FFFC);
    checkOutput("wrap_valid", {31'h0, valid5}, 32'h1);

    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("stall_imem_req", {31'h0, imemReq}, 32'h0);
    checkOutput("stall_id_instr", idInstr, 32'h2008_7FFF);
    checkOutput("stall_id_pc4", idPc4, 32'h4);
    checkOutput("stall_imem_addr", imemAddr, 32'h8);

    expQ.push_back({32'h8C09_FFFC, 32'h0000_0008});
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("resume_imem_req", {31'h0, imemReq}, 32'h1);
    checkOutput("resume_imem_addr", imemAddr, 32'h8);

    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("stall2_imem_addr", imemAddr, 32'hC);
    applyStimulus(1, 0, 1, 32'h0040_0003, 1);
    checkOutput("redir_imem_addr", imemAddr, 32'h0040_0000);
    checkOutput("redir_id_valid", {31'h0, idValid}, 32'h0);
    checkOutput("redir_imem_req", {31'h0, imemReq}, 32'h1);

    expQ.push_back({32'h0800_0010, 32'h0040_0004});
    applyStimulus(0, 0, 0, 0, 1);

    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("flush_id_valid", {31'h0, idValid}, 32'h0);
    checkOutput("flush_id_instr", idInstr, 32'h0);
    checkOutput("flush_imem_addr", imemAddr, 32'h0040_0008);

    expQ.push_back({32'hDEAD_0008, 32'h0040_000C});
    applyStimulus(0, 0, 0, 0, 1);

    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wait1_id_valid", {31'h0, idValid}, 32'h0);
    checkOutput("wait1_imem_addr", imemAddr, 32'h0040_000C);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wait2_id_valid", {31'h0, idValid}, 32'h0);
    checkOutput("wait2_imem_addr", imemAddr, 32'h0040_000C);
`ifdef IF_STALL_CNT_EN
    checkOutput("stall_cnt", stallCnt, 32'd5);
`endif

    expQ.push_back({32'hDEAD_000C, 32'h0040_0010});
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("scoreboard_empty", expQ.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
